// File: rtl/calc_pkg.sv
// Shared state encoding, mode codes and mode validation for the calculator sequencer.
package calc_pkg;

  typedef enum logic [2:0] {
    IDLE1    = 3'd0,
    LOAD1    = 3'd1,
    IDLE2    = 3'd2,
    LOAD2    = 3'd3,
    IDLE3    = 3'd4,
    ISSUE    = 3'd5,
    WAIT_ALU = 3'd6,
    DONE     = 3'd7
  } calc_state_e;

  localparam logic [2:0] MS_NONE = 3'b000;
  localparam logic [2:0] MS_ADD  = 3'b001;
  localparam logic [2:0] MS_SUB  = 3'b010;
  localparam logic [2:0] MS_MUL  = 3'b011;
  localparam logic [2:0] MS_XOR  = 3'b100;

  function automatic logic ms_valid(input logic [2:0] ms);
    return (ms == MS_ADD) || (ms == MS_SUB) || (ms == MS_MUL) || (ms == MS_XOR);
  endfunction

endpackage

// File: rtl/next_edge_sync.sv
// Synchronizes the raw "next" button into the CLK domain and emits a single-cycle
// pulse on each rising edge; holding the button produces no repeats.
module next_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic CLK,
  input  logic clear_n,
  input  logic next,
  output logic next_pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  always_ff @(posedge CLK or negedge clear_n) begin
    if (!clear_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], next};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign next_pulse = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/calc_sequencer.sv
// Calculator sequencer FSM: operand capture, mode select, ALU start/done handshake
// with timeout, result display. Optional macro CALC_CHAIN_EN chains results into RF[0].
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int ALU_TIMEOUT = 15,
  parameter int SYNC_STAGES = 2
) (
  input  logic       CLK,
  input  logic       clear_n,
  input  logic       next,
  input  logic [2:0] MS,
  input  logic       alu_done,
  output logic       WE,
  output logic       W1,
  output logic       din_sel,
  output logic       alu_start,
  output logic [2:0] MS_out,
  output logic       Done_out,
  output logic       err_out,
  output logic [2:0] CS_out
);

  localparam int CW = (ALU_TIMEOUT > 1) ? $clog2(ALU_TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(ALU_TIMEOUT - 1);

  calc_state_e   state_q, state_d;
  logic [2:0]    ms_q, ms_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          next_pulse;

  next_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_next_sync (
    .CLK       (CLK),
    .clear_n   (clear_n),
    .next      (next),
    .next_pulse(next_pulse)
  );

`ifdef CALC_CHAIN_EN
  // Marks a LOAD1 entered from DONE, so the write takes the ALU result.
  logic chain_q, chain_d;
`endif

  always_ff @(posedge CLK or negedge clear_n) begin
    if (!clear_n) begin
      state_q <= IDLE1;
      ms_q    <= MS_NONE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
`ifdef CALC_CHAIN_EN
      chain_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ms_q    <= ms_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`ifdef CALC_CHAIN_EN
      chain_q <= chain_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    ms_d      = ms_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    WE        = 1'b0;
    W1        = 1'b0;
    alu_start = 1'b0;
    MS_out    = MS_NONE;
    Done_out  = 1'b0;
`ifdef CALC_CHAIN_EN
    chain_d   = 1'b0;
`endif
    case (state_q)
      IDLE1: begin
        if (next_pulse) state_d = LOAD1;
      end
      LOAD1: begin
        WE      = 1'b1;
        state_d = IDLE2;
      end
      IDLE2: begin
        W1 = 1'b1;
        if (next_pulse) state_d = LOAD2;
      end
      LOAD2: begin
        WE      = 1'b1;
        W1      = 1'b1;
        state_d = IDLE3;
      end
      IDLE3: begin
        // An invalid mode keeps us here with the error flag raised.
        if (next_pulse) begin
          if (ms_valid(MS)) begin
            state_d = ISSUE;
            ms_d    = MS;
            err_d   = 1'b0;
          end else begin
            err_d   = 1'b1;
          end
        end
      end
      ISSUE: begin
        alu_start = 1'b1;
        MS_out    = ms_q;
        cnt_d     = '0;
        state_d   = WAIT_ALU;
      end
      WAIT_ALU: begin
        // Completion takes priority over timeout in the same cycle.
        MS_out = ms_q;
        cnt_d  = cnt_q + 1'b1;
        if (alu_done) begin
          state_d = DONE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          err_d   = 1'b1;
        end
      end
      DONE: begin
        MS_out   = ms_q;
        Done_out = 1'b1;
        if (next_pulse) begin
`ifdef CALC_CHAIN_EN
          state_d = LOAD1;
          chain_d = 1'b1;
`else
          state_d = IDLE1;
`endif
        end
      end
      default: state_d = IDLE1;
    endcase
  end

`ifdef CALC_CHAIN_EN
  assign din_sel = chain_q;
`else
  assign din_sel = 1'b0;
`endif

  assign err_out = err_q;
  assign CS_out  = state_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Scoreboard bench for calc_sequencer: expected DONE results are queued at the mode
// press and checked when Done_out rises. Works with or without CALC_CHAIN_EN.
module tb_calc_sequencer;

  localparam int TIMEOUT = 15;

  logic       CLK = 1'b0;
  logic       clear_n = 1'b0;
  logic       next = 1'b0;
  logic [2:0] MS = 3'b000;
  logic       alu_done = 1'b0;
  logic       WE, W1, din_sel, alu_start, Done_out, err_out;
  logic [2:0] MS_out, CS_out;

  typedef struct packed {
    logic [2:0] ms;
    logic       err;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;

  calc_sequencer #(
    .ALU_TIMEOUT(TIMEOUT),
    .SYNC_STAGES(2)
  ) dut (
    .CLK      (CLK),
    .clear_n  (clear_n),
    .next     (next),
    .MS       (MS),
    .alu_done (alu_done),
    .WE       (WE),
    .W1       (W1),
    .din_sel  (din_sel),
    .alu_start(alu_start),
    .MS_out   (MS_out),
    .Done_out (Done_out),
    .err_out  (err_out),
    .CS_out   (CS_out)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One-cycle press; returns just after the edge where the FSM acts on it.
  task automatic press();
    next = 1'b1;
    tick();
    next = 1'b0;
    tick();
    tick();
  endtask

  task automatic do_reset();
    next = 1'b0;
    alu_done = 1'b0;
    MS = 3'b000;
    clear_n = 1'b0;
    #2;
    clear_n = 1'b1;
    tick();
  endtask

  task automatic go_to_idle3();
    press();
    tick();
    press();
    tick();
  endtask

  task automatic go_to_issue(input logic [2:0] ms, input logic exp_err);
    go_to_idle3();
    MS = ms;
    sb.push_back('{ms: ms, err: exp_err});
    press();
  endtask

  // Starts in ISSUE; pulses alu_done on cycle done_delay (negative = never).
  task automatic run_alu(input int done_delay, input int exp_cycles, input string name);
    int n = 0;
    int starts = 0;
    bit seen = 0;
    exp_t e;
    while (n < 100 && !seen) begin
      alu_done = (n == done_delay);
      tick();
      n++;
      if (alu_start) starts++;
      if (Done_out) seen = 1;
    end
    alu_done = 1'b0;
    n_checks++;
    if (!seen || n != exp_cycles) begin
      n_fail++;
      $display("[TB] FAIL %s_latency: got %0d cycles (seen=%0d), expected %0d", name, n, seen, exp_cycles);
    end
    n_checks++;
    if (starts != 0) begin
      n_fail++;
      $display("[TB] FAIL %s_extra_start: got %0d extra alu_start, expected 0", name, starts);
    end
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("[TB] FAIL %s_scoreboard: got empty queue, expected an entry", name);
    end else begin
      e = sb.pop_front();
      if (MS_out !== e.ms || err_out !== e.err || CS_out !== 3'd7) begin
        n_fail++;
        $display("[TB] FAIL %s_result: got ms=%b err=%b cs=%0d, expected ms=%b err=%b cs=7",
                 name, MS_out, err_out, CS_out, e.ms, e.err);
      end
    end
  endtask

  task automatic test_reset();
    clear_n = 1'b0;
    next = 1'b1;
    alu_done = 1'b1;
    tick();
    tick();
    n_checks++;
    if ({WE, W1, din_sel, alu_start, MS_out, Done_out, err_out, CS_out} !== 12'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_outputs: got %h, expected 000", {WE, W1, din_sel, alu_start, MS_out, Done_out, err_out, CS_out});
    end
    next = 1'b0;
    alu_done = 1'b0;
    tick();
    clear_n = 1'b1;
    tick();
    alu_done = 1'b1;
    tick();
    alu_done = 1'b0;
    tick();
    tick();
    n_checks++;
    if (CS_out !== 3'd0 || Done_out !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL done_in_idle: got cs=%0d done=%b, expected cs=0 done=0", CS_out, Done_out);
    end
  endtask

  task automatic test_basic();
    do_reset();
    press();
    n_checks++;
    if (CS_out !== 3'd1 || WE !== 1'b1 || W1 !== 1'b0 || din_sel !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL load1: got cs=%0d we=%b w1=%b dsel=%b, expected 1 1 0 0", CS_out, WE, W1, din_sel);
    end
    tick();
    tick();
    tick();
    n_checks++;
    if (CS_out !== 3'd2 || WE !== 1'b0 || W1 !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL idle2: got cs=%0d we=%b w1=%b, expected 2 0 1", CS_out, WE, W1);
    end
    press();
    n_checks++;
    if (CS_out !== 3'd3 || WE !== 1'b1 || W1 !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL load2: got cs=%0d we=%b w1=%b, expected 3 1 1", CS_out, WE, W1);
    end
    tick();
    n_checks++;
    if (CS_out !== 3'd4 || WE !== 1'b0 || MS_out !== 3'b000) begin
      n_fail++;
      $display("[TB] FAIL idle3: got cs=%0d we=%b ms_out=%b, expected 4 0 000", CS_out, WE, MS_out);
    end
    MS = 3'b001;
    sb.push_back('{ms: 3'b001, err: 1'b0});
    press();
    n_checks++;
    if (CS_out !== 3'd5 || alu_start !== 1'b1 || MS_out !== 3'b001) begin
      n_fail++;
      $display("[TB] FAIL issue: got cs=%0d start=%b ms_out=%b, expected 5 1 001", CS_out, alu_start, MS_out);
    end
    run_alu(3, 4, "basic");
  endtask

  task automatic test_invalid_mode();
    do_reset();
    go_to_idle3();
    MS = 3'b110;
    press();
    n_checks++;
    if (CS_out !== 3'd4 || err_out !== 1'b1 || alu_start !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL invalid_110: got cs=%0d err=%b start=%b, expected 4 1 0", CS_out, err_out, alu_start);
    end
    MS = 3'b000;
    press();
    n_checks++;
    if (CS_out !== 3'd4 || err_out !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL invalid_000: got cs=%0d err=%b, expected 4 1", CS_out, err_out);
    end
    MS = 3'b011;
    sb.push_back('{ms: 3'b011, err: 1'b0});
    press();
    n_checks++;
    if (CS_out !== 3'd5 || err_out !== 1'b0 || MS_out !== 3'b011) begin
      n_fail++;
      $display("[TB] FAIL valid_after_invalid: got cs=%0d err=%b ms_out=%b, expected 5 0 011", CS_out, err_out, MS_out);
    end
    MS = 3'b001;
    run_alu(1, 2, "latched_mode");
  endtask

  task automatic test_timeout();
    do_reset();
    go_to_issue(3'b010, 1'b1);
    run_alu(-1, TIMEOUT + 1, "timeout");
    tick();
    tick();
    n_checks++;
    if (err_out !== 1'b1 || Done_out !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL timeout_sticky: got err=%b done=%b, expected 1 1", err_out, Done_out);
    end
    do_reset();
    go_to_issue(3'b011, 1'b0);
    run_alu(TIMEOUT, TIMEOUT + 1, "done_at_timeout");
  endtask

  task automatic test_hold_next();
    int load1_cycles = 0;
    do_reset();
    next = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (CS_out === 3'd1) load1_cycles++;
    end
    next = 1'b0;
    tick();
    n_checks++;
    if (load1_cycles != 1 || CS_out !== 3'd2) begin
      n_fail++;
      $display("[TB] FAIL hold_next: got load1_cycles=%0d cs=%0d, expected 1 2", load1_cycles, CS_out);
    end
  endtask

  task automatic test_next_in_wait();
    exp_t e;
    do_reset();
    go_to_issue(3'b100, 1'b0);
    tick();
    press();
    tick();
    n_checks++;
    if (CS_out !== 3'd6 || MS_out !== 3'b100) begin
      n_fail++;
      $display("[TB] FAIL next_in_wait: got cs=%0d ms_out=%b, expected 6 100", CS_out, MS_out);
    end
    alu_done = 1'b1;
    tick();
    alu_done = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("[TB] FAIL wait_scoreboard: got empty queue, expected an entry");
    end else begin
      e = sb.pop_front();
      if (CS_out !== 3'd7 || Done_out !== 1'b1 || MS_out !== e.ms || err_out !== e.err) begin
        n_fail++;
        $display("[TB] FAIL no_queued_next: got cs=%0d done=%b ms=%b err=%b, expected 7 1 %b %b",
                 CS_out, Done_out, MS_out, err_out, e.ms, e.err);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    go_to_issue(3'b001, 1'b0);
    tick();
    tick();
    #3;
    clear_n = 1'b0;
    #1;
    n_checks++;
    if ({WE, W1, din_sel, alu_start, MS_out, Done_out, err_out, CS_out} !== 12'd0) begin
      n_fail++;
      $display("[TB] FAIL async_reset: got %h, expected 000", {WE, W1, din_sel, alu_start, MS_out, Done_out, err_out, CS_out});
    end
    sb.delete();
    #2;
    clear_n = 1'b1;
    tick();
    alu_done = 1'b1;
    tick();
    alu_done = 1'b0;
    tick();
    n_checks++;
    if (CS_out !== 3'd0 || Done_out !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL late_done: got cs=%0d done=%b, expected 0 0", CS_out, Done_out);
    end
  endtask

  task automatic test_return();
    do_reset();
    go_to_issue(3'b100, 1'b0);
    run_alu(2, 3, "return_op");
    press();
`ifdef CALC_CHAIN_EN
    n_checks++;
    if (CS_out !== 3'd1 || WE !== 1'b1 || W1 !== 1'b0 || din_sel !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL chain_load1: got cs=%0d we=%b w1=%b dsel=%b, expected 1 1 0 1", CS_out, WE, W1, din_sel);
    end
    tick();
    n_checks++;
    if (CS_out !== 3'd2 || din_sel !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL chain_idle2: got cs=%0d dsel=%b, expected 2 0", CS_out, din_sel);
    end
`else
    n_checks++;
    if (CS_out !== 3'd0 || din_sel !== 1'b0 || WE !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL return_idle1: got cs=%0d dsel=%b we=%b, expected 0 0 0", CS_out, din_sel, WE);
    end
`endif
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    #1;
    test_reset();
    test_basic();
    test_invalid_mode();
    test_timeout();
    test_hold_next();
    test_next_in_wait();
    test_async_reset();
    test_return();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
